// File: rtl/elevator_vga_display.sv
// VGA timing generator and elevator-shaft renderer; all outputs registered on the pixel enable.
// Status inputs are shadowed once per frame at vblank start so a frame is always drawn from one snapshot.
module elevator_vga_display #(
    parameter int COLOR_W    = 4,
    parameter int NUM_FLOORS = 8,
    parameter int CLK_DIV    = 2,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int SHAFT_X0   = 256,
    parameter int SHAFT_W    = 128,
    parameter int IND_X0     = 416,
    parameter int IND_W      = 32,
    localparam int FLOOR_W   = $clog2(NUM_FLOORS)
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic [1:0]            sim_state,
    input  logic [NUM_FLOORS-1:0] destination,
    input  logic [FLOOR_W-1:0]    car_floor,
    output logic                  hsync,
    output logic                  vsync,
    output logic [COLOR_W-1:0]    R,
    output logic [COLOR_W-1:0]    G,
    output logic [COLOR_W-1:0]    B,
    output logic                  frame_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BH    = V_ACTIVE / NUM_FLOORS;
    localparam int REM   = V_ACTIVE % NUM_FLOORS;
    localparam int RW    = (BH > 1) ? $clog2(BH) : 1;

    localparam logic [COLOR_W-1:0] C_FULL = '1;
    localparam logic [COLOR_W-1:0] C_MSB  = COLOR_W'(1) << (COLOR_W - 1);
    localparam logic [COLOR_W-1:0] C_LSB  = COLOR_W'(1);

    logic [DW-1:0]         div_cnt;
    logic                  pix_en;
    logic [HW-1:0]         h_cnt;
    logic [VW-1:0]         v_cnt;
    logic                  h_last;
    logic                  v_last;

    logic                  band_vld;
    logic [FLOOR_W-1:0]    band_cnt;
    logic [RW-1:0]         row_in_band;

    logic [1:0]            sh_state;
    logic [NUM_FLOORS-1:0] sh_dest;
    logic [FLOOR_W-1:0]    sh_car;

    int                    hx;
    int                    vy;
    logic                  active;
    logic                  hs_act;
    logic                  vs_act;
    logic                  in_shaft;
    logic                  in_lamp;
    logic [FLOOR_W-1:0]    floor_idx;
    logic [COLOR_W-1:0]    pr, pg, pb;

    assign pix_en = (div_cnt == DW'(CLK_DIV - 1));
    assign h_last = (h_cnt == HW'(H_TOT - 1));
    assign v_last = (v_cnt == VW'(V_TOT - 1));

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (pix_en) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            h_cnt <= h_last ? '0 : h_cnt + HW'(1);
            if (h_last) begin
                v_cnt <= v_last ? '0 : v_cnt + VW'(1);
            end
        end
    end

    // Band state always describes the row v_cnt currently holds; it moves with each line wrap.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            band_vld    <= (REM == 0);
            band_cnt    <= '0;
            row_in_band <= '0;
        end else if (pix_en && h_last) begin
            if (v_last) begin
                band_vld    <= (REM == 0);
                band_cnt    <= '0;
                row_in_band <= '0;
            end else if (!band_vld) begin
                if (REM != 0 && int'(v_cnt) == REM - 1) begin
                    band_vld    <= 1'b1;
                    band_cnt    <= '0;
                    row_in_band <= '0;
                end
            end else if (row_in_band == RW'(BH - 1)) begin
                row_in_band <= '0;
                if (band_cnt == FLOOR_W'(NUM_FLOORS - 1)) begin
                    band_vld <= 1'b0;
                end else begin
                    band_cnt <= band_cnt + FLOOR_W'(1);
                end
            end else begin
                row_in_band <= row_in_band + RW'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            sh_state <= '0;
            sh_dest  <= '0;
            sh_car   <= '0;
        end else if (pix_en && h_cnt == '0 && v_cnt == VW'(V_ACTIVE)) begin
            sh_state <= sim_state;
            sh_dest  <= destination;
            sh_car   <= (int'(car_floor) >= NUM_FLOORS) ? FLOOR_W'(NUM_FLOORS - 1) : car_floor;
        end
    end

    assign hx        = int'(h_cnt);
    assign vy        = int'(v_cnt);
    assign active    = (hx < H_ACTIVE) && (vy < V_ACTIVE);
    assign hs_act    = (hx >= H_ACTIVE + H_FP) && (hx < H_ACTIVE + H_FP + H_SYNC);
    assign vs_act    = (vy >= V_ACTIVE + V_FP) && (vy < V_ACTIVE + V_FP + V_SYNC);
    assign in_shaft  = (hx >= SHAFT_X0) && (hx < SHAFT_X0 + SHAFT_W);
    assign in_lamp   = (hx >= IND_X0) && (hx < IND_X0 + IND_W);
    // Band 0 is the top of the screen, i.e. the highest floor.
    assign floor_idx = FLOOR_W'(NUM_FLOORS - 1) - band_cnt;

    always_comb begin
        pr = '0;
        pg = '0;
        pb = '0;
        if (active && band_vld) begin
            if (row_in_band == '0) begin
                pr = C_MSB;
                pg = C_MSB;
                pb = C_MSB;
            end else if (in_shaft && floor_idx == sh_car) begin
                case (sh_state)
                    2'd0: begin
                        pr = C_FULL;
                        pg = C_FULL;
                        pb = C_FULL;
                    end
                    2'd1:    pg = C_FULL;
                    2'd2:    pb = C_FULL;
                    default: pr = C_FULL;
                endcase
            end else if (in_shaft) begin
                pr = C_LSB;
                pg = C_LSB;
                pb = C_LSB;
            end else if (in_lamp && sh_dest[floor_idx]) begin
                pr = C_FULL;
                pg = C_FULL;
            end
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            R           <= '0;
            G           <= '0;
            B           <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en && h_last && v_last;
            if (pix_en) begin
                R     <= pr;
                G     <= pg;
                B     <= pb;
                hsync <= SYNC_POL ? hs_act : ~hs_act;
                vsync <= SYNC_POL ? vs_act : ~vs_act;
            end
        end
    end

endmodule

// File: tb/tb_elevator_vga_display.sv
// Randomized bench for elevator_vga_display on a reduced raster, checked every clock against a reference model.
module tb_elevator_vga_display;

    localparam int CD  = 2;
    localparam int HA  = 40, HF = 4, HS = 6, HB = 6;
    localparam int VA  = 32, VF = 2, VS = 2, VB = 3;
    localparam int HT  = HA + HF + HS + HB;
    localparam int VT  = VA + VF + VS + VB;
    localparam int FT  = HT * VT;
    localparam int NF  = 6;
    localparam int BH  = VA / NF;
    localparam int REM = VA % NF;
    localparam int SX  = 10, SW = 12, LX = 26, LW = 6;

    logic          clk;
    logic          reset;
    logic [1:0]    sim_state;
    logic [NF-1:0] destination;
    logic [2:0]    car_floor;
    logic          hsync, vsync, frame_start;
    logic [3:0]    R, G, B;

    int checks;
    int errors;
    int t;

    logic [1:0]    m_state;
    logic [NF-1:0] m_dest;
    int            m_car;

    elevator_vga_display #(
        .COLOR_W(4), .NUM_FLOORS(NF), .CLK_DIV(CD),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0),
        .SHAFT_X0(SX), .SHAFT_W(SW), .IND_X0(LX), .IND_W(LW)
    ) dut (
        .CLK(clk),
        .reset(reset),
        .sim_state(sim_state),
        .destination(destination),
        .car_floor(car_floor),
        .hsync(hsync),
        .vsync(vsync),
        .R(R),
        .G(G),
        .B(B),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%h expected=%h", tag, t, got, exp);
        end
    endtask

    // Expected {R,G,B} for screen position (x,y) from the current model snapshot.
    function automatic logic [11:0] ref_rgb(input int x, input int y);
        int fl;
        if (x >= HA || y >= VA || y < REM) return 12'h000;
        if ((y - REM) % BH == 0) return 12'h888;
        fl = NF - 1 - (y - REM) / BH;
        if (x >= SX && x < SX + SW) begin
            if (fl == m_car) begin
                case (m_state)
                    2'd0:    return 12'hFFF;
                    2'd1:    return 12'h0F0;
                    2'd2:    return 12'h00F;
                    default: return 12'hF00;
                endcase
            end
            return 12'h111;
        end
        if (x >= LX && x < LX + LW && m_dest[fl]) return 12'hFF0;
        return 12'h000;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rgb"}, {20'h0, R, G, B}, 32'h0);
        chk({tag, "_hs"}, {31'h0, hsync}, 32'h1);
        chk({tag, "_vs"}, {31'h0, vsync}, 32'h1);
        chk({tag, "_fs"}, {31'h0, frame_start}, 32'h0);
    endtask

    task automatic randomize_inputs();
        sim_state   = 2'($urandom_range(0, 3));
        destination = NF'($urandom);
        car_floor   = 3'($urandom_range(0, 7));
    endtask

    // One clock: advance the model, compare all outputs, occasionally change inputs.
    task automatic step(input int change_odds);
        int n, h, v;
        logic [11:0] e_rgb;
        logic e_hs, e_vs, e_fs;
        @(negedge clk);
        t++;
        if (t % CD == 0) begin
            n = t / CD - 1;
            if (n % HT == 0 && (n / HT) % VT == VA) begin
                m_state = sim_state;
                m_dest  = destination;
                m_car   = (int'(car_floor) >= NF) ? NF - 1 : int'(car_floor);
            end
        end
        n = t / CD - 1;
        if (n < 0) begin
            e_rgb = 12'h000;
            e_hs  = 1'b1;
            e_vs  = 1'b1;
            e_fs  = 1'b0;
        end else begin
            h     = n % HT;
            v     = (n / HT) % VT;
            e_rgb = ref_rgb(h, v);
            e_hs  = !(h >= HA + HF && h < HA + HF + HS);
            e_vs  = !(v >= VA + VF && v < VA + VF + VS);
            e_fs  = (t % CD == 0) && (n % FT == FT - 1);
        end
        chk("rgb", {20'h0, R, G, B}, {20'h0, e_rgb});
        chk("hsync", {31'h0, hsync}, {31'h0, e_hs});
        chk("vsync", {31'h0, vsync}, {31'h0, e_vs});
        chk("frame_start", {31'h0, frame_start}, {31'h0, e_fs});
        if (change_odds > 0 && $urandom_range(0, change_odds - 1) == 0) randomize_inputs();
    endtask

    task automatic clear_model();
        t       = 0;
        m_state = 2'd0;
        m_dest  = '0;
        m_car   = 0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        sim_state   = 2'd1;
        destination = 6'b100001;
        car_floor   = 3'd7;
        clear_model();
        #1;
        check_reset_vals("por");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        clear_model();

        // Frame 0 must still draw the zero snapshot despite the non-zero inputs.
        for (int i = 0; i < FT * CD; i++) step(0);
        sim_state   = 2'd3;
        car_floor   = 3'd2;
        destination = 6'b010010;
        for (int i = 0; i < FT * CD; i++) step(0);
        for (int i = 0; i < 2 * FT * CD; i++) step(150);

        // Async reset in the middle of the active area.
        for (int i = 0; i < (HT * 20 + 30) * CD; i++) step(150);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("mid");
        repeat (3) @(negedge clk);
        check_reset_vals("held");
        reset = 1'b0;
        clear_model();
        for (int i = 0; i < 3 * FT * CD; i++) step(120);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
